sample_sequencer: RTL and testbench
===================================

Name: sample_sequencer

Overview:
- Per-sample controller for the audio path ADC -> filter bank -> filter mux -> DAC.
- Generates the sample-rate tick and pulses the ADC start. Waits for ADC done, then enables the filter stage for a fixed latency, loads the DAC holding register, and starts and waits on the DAC transfer.
- Owns the filter-select register so the selection only changes on a frame boundary. Detects overrun and handshake timeouts.

Parameters:
- SAMPLE_DIV, 5000: clock_In cycles per sample period (tick period); must be > worst-case frame length.
- FILT_LAT, 4: cycles to hold in FILT_WAIT after the filter enable pulse.
- TIMEOUT, 1023: maximum cycles allowed in ADC_WAIT or DAC_WAIT.
- CNT_W, 16: width of the tick counter, watchdog and sample_count.

Ports:
- clock_In  in  1  system clock; all logic rising-edge.
- Reset  in  1  synchronous, active-low reset.
- run  in  1  level; 1 = sequence samples continuously.
- filtro_req  in  2  requested filter: 00 bajos, 01 medios, 10 altos, 11 reserved.
- adc_done  in  1  ADC interface done; rising edge detected internally.
- dac_done  in  1  DAC protocol done; rising edge detected internally.
- clear_err  in  1  clears the sticky error flags.
- adc_start  out  1  one-cycle start pulse to the ADC interface.
- filt_enable  out  1  one-cycle enable pulse to the filter stage.
- dac_load  out  1  one-cycle load strobe for the DAC holding register.
- dac_start  out  1  one-cycle start pulse to the DAC protocol.
- filtro  out  2  applied filter select (drives the mux).
- busy  out  1  1 in any state other than IDLE/WAIT_TICK.
- overrun  out  1  sticky: a tick arrived while a frame was in progress.
- timeout_err  out  1  sticky: an ADC_WAIT or DAC_WAIT watchdog expired.
- sample_count  out  CNT_W  completed frames, wraps at 2^CNT_W.

Behaviour:
- Reset (Reset==0 at an edge) forces:
  - all outputs to 0, filtro=00;
  - state IDLE; tick counter, watchdog and edge-detect registers to 0.
  - Reset mid-frame abandons the frame immediately; no further pulses are issued.
- Tick counter:
  - counts 0..SAMPLE_DIV-1 while run=1 and produces tick=1 on the cycle the count equals SAMPLE_DIV-1;
  - is held at 0 while run=0.
- adc_done/dac_done are registered once; an event is prev==0 && cur==1.
- FSM:
  - IDLE: when run=1, go to WAIT_TICK.
  - WAIT_TICK: on tick, go to ADC_START. If run=0, go to IDLE.
  - ADC_START: adc_start=1 for one cycle; clear the watchdog; go to ADC_WAIT.
  - ADC_WAIT: on adc_done event, go to FILT_EN. If the watchdog reaches TIMEOUT, set timeout_err and go to WAIT_TICK.
  - FILT_EN: latch filtro <= filtro_req unless filtro_req==11 (then hold the previous value); filt_enable=1 for one cycle; go to FILT_WAIT.
  - FILT_WAIT: count FILT_LAT cycles, then go to DAC_LOAD.
  - DAC_LOAD: dac_load=1 for one cycle; go to DAC_START.
  - DAC_START: dac_start=1 for one cycle; clear the watchdog; go to DAC_WAIT.
  - DAC_WAIT: on dac_done event, sample_count+1, then go to WAIT_TICK (or to IDLE if run=0). On watchdog = TIMEOUT, set timeout_err and go to WAIT_TICK; sample_count is not incremented.
- Latency in clock_In cycles:
  - tick to adc_start: 1;
  - adc_done edge (at pin) to filt_enable: 2;
  - filt_enable to dac_load: FILT_LAT+1;
  - dac_load to dac_start: 1.
- Overrun:
  - a tick occurring in any state other than WAIT_TICK sets overrun and is dropped;
  - the current frame continues, and the next frame waits for the following tick.
- run falling mid-frame: the frame completes normally, then the FSM enters IDLE.
- clear_err=1 clears overrun and timeout_err. If a set condition occurs in the same cycle, the set wins.
- Outputs are registered; no pulse lasts more than one cycle.

Decomposition:
- Shared package: FSM state encoding (9 states, 4-bit) and the filter select codes (BAJOS=00, MEDIOS=01, ALTOS=10).
- One natural sub-module, sample_tick_gen: the parameterised SAMPLE_DIV counter with run gating.
- The edge detectors, watchdog and FSM stay in the top module.

Test Plan:
- Nominal frame: SAMPLE_DIV=20, FILT_LAT=4; adc_done rises 5 cycles after adc_start; dac_done rises 8 cycles after dac_start. Required: exact pulse spacing per the latencies above; sample_count=1; busy low after completion; next adc_start 20 cycles after the previous one.
- Filter select: filtro_req=10 then 11 across two frames. Required: filtro=10 after the first filt_enable and still 10 after the second. A change of filtro_req in mid-frame has no effect until the next FILT_EN.
- Timeout: TIMEOUT=15, adc_done never rises. Required: timeout_err=1 exactly 15 cycles into ADC_WAIT; no filt_enable; sample_count unchanged. clear_err then clears the flag.
- Overrun: dac_done delayed past the next tick. Required: overrun=1 at the tick cycle; that tick produces no adc_start; the following tick starts a frame.
- Reset and run: assert Reset=0 while in DAC_WAIT. Required: all outputs 0 and filtro=00 on the next edge. Drop run mid-frame. Required: the frame completes, then IDLE, with the tick counter held at 0.
- Wrap: CNT_W=4, run 16 frames. Required: sample_count returns to 0.

Source files
------------

// File: rtl/sample_sequencer_pkg.sv
// sample_sequencer_pkg: frame FSM state encoding and filter select codes
package sample_sequencer_pkg;
  typedef enum logic [3:0] {
    IDLE,
    WAIT_TICK,
    ADC_START,
    ADC_WAIT,
    FILT_EN,
    FILT_WAIT,
    DAC_LOAD,
    DAC_START,
    DAC_WAIT
  } state_t;
  localparam logic [1:0] BAJOS = 2'b00;
  localparam logic [1:0] MEDIOS = 2'b01;
  localparam logic [1:0] ALTOS = 2'b10;
  function automatic logic filt_valid(input logic [1:0] f);
    return f inside {BAJOS, MEDIOS, ALTOS};
  endfunction
endpackage

// File: rtl/sample_sequencer_tick.sv
// sample_tick_gen: run-gated sample-period counter, ticks on its last count
module sample_tick_gen #(
  parameter int SAMPLE_DIV = 5000
) (
  input  logic clock_In,
  input  logic Reset,
  input  logic run,
  output logic tick
);
  localparam int W = $clog2(SAMPLE_DIV + 1);
  logic [W-1:0] count;
  assign tick = run && count == W'(SAMPLE_DIV - 1);
  always_ff @(posedge clock_In)
    count <= (!Reset || !run || tick) ? '0 : count + 1'b1;
endmodule

// File: rtl/sample_sequencer.sv
// sample_sequencer: per-sample ADC -> filter -> DAC frame controller with overrun and timeout detection
module sample_sequencer #(
  parameter int SAMPLE_DIV = 5000,
  parameter int FILT_LAT = 4,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W = 16
) (
  input  logic             clock_In,
  input  logic             Reset,
  input  logic             run,
  input  logic [1:0]       filtro_req,
  input  logic             adc_done,
  input  logic             dac_done,
  input  logic             clear_err,
  output logic             adc_start,
  output logic             filt_enable,
  output logic             dac_load,
  output logic             dac_start,
  output logic [1:0]       filtro,
  output logic             busy,
  output logic             overrun,
  output logic             timeout_err,
  output logic [CNT_W-1:0] sample_count
);
  import sample_sequencer_pkg::*;
  state_t state;
  logic tick, adc_cur, adc_prev, dac_cur, dac_prev;
  logic [CNT_W-1:0] wd;
  logic adc_ev, dac_ev, wd_exp;
  assign adc_ev = adc_cur && !adc_prev;
  assign dac_ev = dac_cur && !dac_prev;
  assign wd_exp = wd == CNT_W'(TIMEOUT - 1);
  sample_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .clock_In(clock_In),
    .Reset(Reset),
    .run(run),
    .tick(tick)
  );
  // wd free-runs; each wait state clears it on entry and also reuses it as the filter latency counter
  always_ff @(posedge clock_In) begin
    if (!Reset) begin
      state <= IDLE;
      wd <= '0;
      adc_cur <= 1'b0;
      adc_prev <= 1'b0;
      dac_cur <= 1'b0;
      dac_prev <= 1'b0;
      adc_start <= 1'b0;
      filt_enable <= 1'b0;
      dac_load <= 1'b0;
      dac_start <= 1'b0;
      filtro <= BAJOS;
      busy <= 1'b0;
      overrun <= 1'b0;
      timeout_err <= 1'b0;
      sample_count <= '0;
    end else begin
      adc_cur <= adc_done;
      adc_prev <= adc_cur;
      dac_cur <= dac_done;
      dac_prev <= dac_cur;
      adc_start <= 1'b0;
      filt_enable <= 1'b0;
      dac_load <= 1'b0;
      dac_start <= 1'b0;
      wd <= wd + 1'b1;
      if (clear_err) begin
        overrun <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (tick && state != WAIT_TICK) overrun <= 1'b1;
      case (state)
        IDLE: if (run) state <= WAIT_TICK;
        WAIT_TICK:
          if (tick) begin
            state <= ADC_START;
            adc_start <= 1'b1;
            busy <= 1'b1;
          end else if (!run) state <= IDLE;
        ADC_START: begin
          wd <= '0;
          state <= ADC_WAIT;
        end
        ADC_WAIT:
          if (adc_ev) begin
            state <= FILT_EN;
            filt_enable <= 1'b1;
          end else if (wd_exp) begin
            timeout_err <= 1'b1;
            busy <= 1'b0;
            state <= WAIT_TICK;
          end
        FILT_EN: begin
          if (filt_valid(filtro_req)) filtro <= filtro_req;
          wd <= '0;
          state <= FILT_WAIT;
        end
        FILT_WAIT:
          if (wd == CNT_W'(FILT_LAT - 1)) begin
            state <= DAC_LOAD;
            dac_load <= 1'b1;
          end
        DAC_LOAD: begin
          state <= DAC_START;
          dac_start <= 1'b1;
        end
        DAC_START: begin
          wd <= '0;
          state <= DAC_WAIT;
        end
        DAC_WAIT:
          if (dac_ev) begin
            sample_count <= sample_count + 1'b1;
            busy <= 1'b0;
            state <= run ? WAIT_TICK : IDLE;
          end else if (wd_exp) begin
            timeout_err <= 1'b1;
            busy <= 1'b0;
            state <= WAIT_TICK;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sample_sequencer.sv
// tb_sample_sequencer: frame-level timing model of sample_sequencer driven by directed and random frames
module tb_sample_sequencer;
  localparam int DIV = 20, FL = 4, TO = 15, CW = 4;
  logic clk = 0, rst_n = 0, run = 0, adc_done = 0, dac_done = 0, clear_err = 0;
  logic [1:0] filtro_req = 0;
  logic adc_start, filt_enable, dac_load, dac_start, busy, overrun, timeout_err;
  logic [1:0] filtro;
  logic [CW-1:0] sample_count;
  int total = 0, bad = 0, cyc = 0, fe_seen = 0, long_pulse = 0;
  int exp_start = 0, mcount = 0, done_frames = 0;
  logic [1:0] mfilt = 0;
  logic exp_ovr = 0;
  logic [3:0] prev_p = 0;

  sample_sequencer #(.SAMPLE_DIV(DIV), .FILT_LAT(FL), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock_In(clk), .Reset(rst_n), .run(run), .filtro_req(filtro_req),
    .adc_done(adc_done), .dac_done(dac_done), .clear_err(clear_err),
    .adc_start(adc_start), .filt_enable(filt_enable), .dac_load(dac_load),
    .dac_start(dac_start), .filtro(filtro), .busy(busy), .overrun(overrun),
    .timeout_err(timeout_err), .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    cyc++;
    clear_err = 0;
    if (filt_enable) fe_seen++;
    if ((prev_p & {adc_start, filt_enable, dac_load, dac_start}) != 0) long_pulse++;
    prev_p = {adc_start, filt_enable, dac_load, dac_start};
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic pick(input int w);
    return w == 0 ? adc_start : w == 1 ? filt_enable : w == 2 ? dac_load : dac_start;
  endfunction

  task automatic wait_out(input int w, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit && at < 0; i++) begin
      if (pick(w)) at = cyc;
      else step();
    end
  endtask

  // ad/dd: cycles from adc_start to adc_done and from dac_start to dac_done; 0 means never
  task automatic frame(input int ad, input int dd, input logic [1:0] nreq, input logic drop);
    int a, f, l, s, e, nxt;
    wait_out(0, 3 * DIV, a);
    chk("adc_start_time", a, exp_start);
    chk("overrun_at_start", overrun, exp_ovr);
    if (a < 0) return;
    clear_err = 1;
    f = fe_seen;
    repeat (ad > 0 ? ad : TO) step();
    if (ad == 0) begin
      chk("adc_to_early", timeout_err, 0);
      step();
      chk("adc_to_set", timeout_err, 1);
      chk("adc_to_nofilt", fe_seen, f);
      chk("adc_to_count", sample_count, mcount);
      e = cyc;
    end else begin
      adc_done = 1;
      wait_out(1, 10, f);
      chk("filt_lat", f, a + ad + 2);
      chk("busy_mid", busy, 1);
      if (filtro_req != 2'b11) mfilt = filtro_req;
      step();
      chk("filtro", filtro, mfilt);
      filtro_req = nreq;
      if (drop) run = 0;
      wait_out(2, 10, l);
      chk("load_lat", l, f + FL + 1);
      wait_out(3, 5, s);
      chk("start_lat", s, l + 1);
      adc_done = 0;
      repeat (dd > 0 ? dd : TO) step();
      if (dd == 0) begin
        chk("dac_to_early", timeout_err, 0);
        step();
        chk("dac_to_set", timeout_err, 1);
      end else begin
        dac_done = 1;
        step();
        step();
        mcount = (mcount + 1) % (1 << CW);
        done_frames++;
        dac_done = 0;
      end
      e = cyc;
      chk("count", sample_count, mcount);
      chk("filtro_hold", filtro, mfilt);
    end
    chk("busy_end", busy, 0);
    nxt = a + DIV;
    while (nxt - 1 < e) nxt += DIV;
    exp_ovr = nxt != a + DIV;
    chk("overrun_end", overrun, exp_ovr);
    exp_start = nxt;
    if (ad == 0 || dd == 0) begin
      clear_err = 1;
      step();
      chk("err_clear", {overrun, timeout_err}, 0);
      exp_ovr = 0;
    end
  endtask

  initial begin
    int a, s, x;
    repeat (3) step();
    chk("rst_pulses", {adc_start, filt_enable, dac_load, dac_start}, 0);
    chk("rst_flags", {busy, overrun, timeout_err}, 0);
    chk("rst_filtro", filtro, 0);
    chk("rst_count", sample_count, 0);
    rst_n = 1;
    run = 1;
    exp_start = cyc + DIV;
    filtro_req = 2'b10;
    frame(3, 4, 2'b11, 0);
    frame(3, 4, 2'b01, 0);
    frame(6, 8, 2'b00, 0);
    frame(0, 0, 2'b00, 0);
    frame(2, 0, 2'b10, 0);
    frame(2, 3, 2'b10, 1);
    wait_out(0, 3 * DIV, x);
    chk("idle_no_start", x, -1);
    chk("idle_busy", busy, 0);
    run = 1;
    exp_start = cyc + DIV;
    exp_ovr = 0;
    frame(1, 2, 2'b10, 0);
    wait_out(0, 3 * DIV, a);
    chk("rst_frame_start", a, exp_start);
    repeat (2) step();
    adc_done = 1;
    wait_out(3, 20, s);
    chk("rst_dac_start", s, a + 2 + 2 + FL + 1 + 1);
    step();
    rst_n = 0;
    step();
    chk("midrst_pulses", {adc_start, filt_enable, dac_load, dac_start}, 0);
    chk("midrst_flags", {busy, overrun, timeout_err}, 0);
    chk("midrst_filtro", filtro, 0);
    chk("midrst_count", sample_count, 0);
    adc_done = 0;
    rst_n = 1;
    mcount = 0;
    mfilt = 0;
    exp_ovr = 0;
    done_frames = 0;
    exp_start = cyc + DIV;
    for (int k = 0; k < 60 && done_frames < 16; k++)
      frame($urandom_range(1, 6), ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 8),
            2'($urandom), 0);
    chk("wrap_frames", done_frames, 16);
    chk("wrap_count", sample_count, 0);
    chk("pulse_width", long_pulse, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
